// File: rtl/march_bist_ctrl.sv
// march_bist_ctrl
// March C- memory BIST controller. It drives a single-port synchronous memory
// through the six March C- elements and compares every read against the value
// that element expects. It reports a sticky fail flag together with the
// address and element of the first miscompare.
//
// Ports
//   clk        : single clock, all logic on the rising edge
//   rst        : synchronous active-high reset, has priority over start
//   start      : begin a test; sampled only in IDLE or DONE
//   mem_addr   : memory address (holds its last value outside RUN)
//   mem_we     : write strobe, the write happens at the same rising edge
//   mem_re     : read strobe, the memory returns data on the next cycle
//   mem_wdata  : write data, all-0s or all-1s (holds its last value outside RUN)
//   mem_rdata  : read data, valid on the cycle after mem_re
//   busy       : test in progress (RUN or DRAIN)
//   done       : level, test finished; held until the next accepted start
//   fail       : sticky miscompare flag
//   fail_addr  : address of the first miscompare
//   fail_elem  : March element (0-5) of the first miscompare
module march_bist_ctrl #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 4,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        elem_q, elem_d;
  logic              wr_ph_q, wr_ph_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic start_ok;
  logic last_at_addr;
  logic at_end;
  logic miscmp;

  logic              vld_p0;
  logic [DATA_W-1:0] exp_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [2:0]        elem_p0;

  logic              fail_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [2:0]        fail_elem_q;

  // E3 and E4 walk the address space downwards.
  function automatic logic is_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic has_rd(input logic [2:0] e);
    return e != 3'd0;
  endfunction

  function automatic logic has_wr(input logic [2:0] e);
    return e != 3'd5;
  endfunction

  // Odd elements (E1, E3) write ones; E0, E2, E4 write zeros.
  function automatic logic [DATA_W-1:0] wr_val(input logic [2:0] e);
    return e[0] ? '1 : '0;
  endfunction

  // Even elements (E2, E4) expect ones; E1, E3, E5 expect zeros.
  function automatic logic [DATA_W-1:0] rd_val(input logic [2:0] e);
    return e[0] ? '0 : '1;
  endfunction

  function automatic logic [ADDR_W-1:0] first_addr(input logic [2:0] e);
    return is_down(e) ? '1 : '0;
  endfunction

  function automatic logic [ADDR_W-1:0] last_addr(input logic [2:0] e);
    return is_down(e) ? '0 : '1;
  endfunction

  assign start_ok     = start && ((state_q == IDLE) || (state_q == DONE));
  // The write phase, or the only op of a single-op element, finishes the address.
  assign last_at_addr = wr_ph_q || !has_wr(elem_q);
  assign at_end       = (addr_q == last_addr(elem_q));
  assign miscmp       = vld_p0 && (mem_rdata != exp_p0);

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    wr_ph_d = wr_ph_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          state_d = RUN;
          elem_d  = 3'd0;
          wr_ph_d = 1'b1;
          addr_d  = '0;
          wdata_d = '0;
        end
      end
      RUN: begin
        if (STOP_ON_FAIL && miscmp) begin
          state_d = DONE;
        end else if (!last_at_addr) begin
          // Read done; the write to the same address follows.
          wr_ph_d = 1'b1;
          wdata_d = wr_val(elem_q);
        end else if (!at_end) begin
          addr_d  = is_down(elem_q) ? addr_q - 1'b1 : addr_q + 1'b1;
          wr_ph_d = !has_rd(elem_q);
        end else if (elem_q == 3'd5) begin
          state_d = DRAIN;
        end else begin
          elem_d  = elem_q + 3'd1;
          addr_d  = first_addr(elem_q + 3'd1);
          wr_ph_d = 1'b0;
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      elem_q  <= 3'd0;
      wr_ph_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      wr_ph_q <= wr_ph_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Stage p0: capture what each read expects; the compare runs on the next cycle.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= mem_re;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_re) begin
      exp_p0  <= rd_val(elem_q);
      addr_p0 <= addr_q;
      elem_p0 <= elem_q;
    end
  end

  // Stage p1: the compare result lands in the sticky fail registers.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= 3'd0;
    end else if (miscmp && !fail_q) begin
      fail_q      <= 1'b1;
      fail_addr_q <= addr_p0;
      fail_elem_q <= elem_p0;
    end
  end

  // Strobes are gated by rst so an aborting reset never issues an op.
  assign mem_we    = (state_q == RUN) && wr_ph_q && !rst;
  assign mem_re    = (state_q == RUN) && !wr_ph_q && !rst;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;

endmodule

// File: doc/march_bist_ctrl.md
MARCH_BIST_CTRL -- requirements
Module: march_bist_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width; depth = 2**ADDR_W.
REQ-002 Parameter DATA_W, default 4, memory data width.
REQ-003 Parameter STOP_ON_FAIL, default 0; 1 = abort test at first miscompare.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  begin test; sampled only in IDLE or DONE.
REQ-007 mem_addr  out  ADDR_W  memory address.
REQ-008 mem_we  out  1  write strobe; write occurs at the same rising edge.
REQ-009 mem_re  out  1  read strobe; memory returns data one cycle later.
REQ-010 mem_wdata  out  DATA_W  write data, all-0s or all-1s.
REQ-011 mem_rdata  in  DATA_W  read data, valid the cycle after mem_re.
REQ-012 busy  out  1  high from the cycle after start is accepted until done rises.
REQ-013 done  out  1  level; held until the next accepted start or rst.
REQ-014 fail  out  1  sticky miscompare flag; cleared on accepted start or rst.
REQ-015 fail_addr  out  ADDR_W  address of the first miscompare.
REQ-016 fail_elem  out  3  march element index (0-5) of the first miscompare.

Function
REQ-017 Algorithm is March C-: E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0).
REQ-018 "0"/"1" are DATA_W-wide all-zeros/all-ones; expected read data is the value the element reads.
REQ-019 FSM states: IDLE, RUN, DRAIN, DONE; element index 0-5 and op phase (read/write) are held in registers.
REQ-020 IDLE/DONE + start=1 -> RUN; first op in the next cycle; address 0 for up elements, 2**ADDR_W-1 for down elements.
REQ-021 Exactly one memory op per RUN cycle, no idle cycles; mem_we and mem_re never both high.
REQ-022 In read-then-write elements, the read and write cycles use the same address; the address advances after the write.
REQ-023 Address wraps at the element boundary; up elements end at 2**ADDR_W-1 and down elements end at 0; the next element starts at its own start address in the next cycle.
REQ-024 Total op cycles = 10 * 2**ADDR_W (2560 at default).
REQ-025 Compare pipeline: the expected value, address and element of each read are registered with mem_re; mem_rdata is compared the following cycle; fail/fail_addr/fail_elem update one edge after that compare.
REQ-026 Only the first miscompare loads fail_addr/fail_elem; later miscompares do not change them.
REQ-027 After the last E5 read -> DRAIN for 1 cycle; done=1 and busy=0 two cycles after the last read cycle, coincident with the last compare's fail update.
REQ-028 STOP_ON_FAIL=1: on detected miscompare -> DONE the next cycle; ops issued during the compare latency still complete, and no further ops start.
REQ-029 Outside RUN: mem_we=0, mem_re=0; mem_addr and mem_wdata hold their last value.
REQ-030 start while busy is ignored.
REQ-031 Widths follow the parameters with no truncation; the address counter is exactly ADDR_W bits; element/op counters are independent of ADDR_W.

Reset
REQ-032 rst=1 at any edge -> IDLE; busy=0, done=0, fail=0, fail_addr=0, fail_elem=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
REQ-033 rst mid-test aborts immediately; no memory op is issued in the rst cycle or the cycle after it.
REQ-034 rst has priority over start in the same cycle.

Verification
REQ-035 Fault-free model, ADDR_W=8, DATA_W=4, start pulse at cycle 0 -> 2560 op cycles, done=1 at cycle 2562, fail=0.
REQ-036 Stuck-at-1 bit0 at address 0x5A -> fail=1, fail_addr=0x5A, fail_elem=1; test runs to completion (STOP_ON_FAIL=0).
REQ-037 Same fault with STOP_ON_FAIL=1 -> done within 3 cycles of the failing read; no ops after that; fail_elem=1.
REQ-038 ADDR_W=3, DATA_W=8 -> op order checked against a golden 80-op list, including the down-element wrap from 7 to 0.
REQ-039 rst asserted at op 1000, then start -> outputs at reset values; the fresh run passes with fail=0.
REQ-040 start pulses while busy, and start with rst in the same cycle -> both ignored; the run's op count is unchanged.
